// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//
// Central stall/flush controller for the 5-stage pipeline. Every cycle it
// decides which pipeline registers hold (stall_at_*) and which load a bubble
// (bubble_at_*), selects the next PC source and tracks the privilege bit.
// A small FSM arbitrates the single memory port between I-cache and D-cache
// refills, and a saturating counter counts cycles in which fetch is stalled.
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   dec_rs, dec_rt            source registers of the instruction in ID
//   dec_uses_rt               ID instruction reads rt
//   ex_memRead, ex_rt         load in EX and its destination register
//   branch_taken              branch resolved taken in EX
//   exception_at_wb           exception retiring in WB
//   iret_at_wb                iret retiring in WB
//   ic_miss, dc_miss          I-cache miss in IF / D-cache miss in MEM
//   mem_ack                   memory port refill complete (one-cycle pulse)
//   mem_req, mem_grant_dc     memory port request / D-cache owns transfer
//   stall_at_*                hold PC / if_id / id_ex / ex_mem
//   bubble_at_*               zero if_id / id_ex / ex_mem / mem_wb
//   pc_sel                    0 seq, 1 branch, 2 exception vector, 3 iret
//   privilege                 1 = supervisor
//   stall_cycles              saturating count of fetch-stall cycles
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_uses_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             exception_at_wb,
  input  logic             iret_at_wb,
  input  logic             ic_miss,
  input  logic             dc_miss,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_grant_dc,
  output logic             stall_at_fetch,
  output logic             stall_at_decode,
  output logic             stall_at_exec,
  output logic             stall_at_mem,
  output logic             bubble_at_decode,
  output logic             bubble_at_exec,
  output logic             bubble_at_mem,
  output logic             bubble_at_wb,
  output logic [1:0]       pc_sel,
  output logic             privilege,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IFILL = 2'd1,
    DFILL = 2'd2,
    DRAIN = 2'd3
  } mem_state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mem_state_e       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             grant_dc_q, grant_dc_d;
  logic             privilege_q, privilege_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic flush;
  logic load_use;

  assign flush    = exception_at_wb | iret_at_wb;
  assign load_use = ex_memRead && (ex_rt != 5'd0) &&
                    ((ex_rt == dec_rs) || (dec_uses_rt && (ex_rt == dec_rt)));

  // Stall / bubble / pc_sel decode, highest priority first.
  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    stall_at_fetch   = 1'b0;
    stall_at_decode  = 1'b0;
    stall_at_exec    = 1'b0;
    stall_at_mem     = 1'b0;
    bubble_at_decode = 1'b0;
    bubble_at_exec   = 1'b0;
    bubble_at_mem    = 1'b0;
    bubble_at_wb     = 1'b0;
    pc_sel           = 2'd0;
    if (flush) begin
      bubble_at_decode = 1'b1;
      bubble_at_exec   = 1'b1;
      bubble_at_mem    = 1'b1;
      bubble_at_wb     = 1'b1;
      pc_sel           = exception_at_wb ? 2'd2 : 2'd3;
    end else if (dc_miss || (state_q == DFILL)) begin
      // Whole pipe freezes; WB retires a bubble while MEM waits for data.
      stall_at_fetch  = 1'b1;
      stall_at_decode = 1'b1;
      stall_at_exec   = 1'b1;
      stall_at_mem    = 1'b1;
      bubble_at_wb    = 1'b1;
    end else begin
      if (load_use) begin
        stall_at_fetch  = 1'b1;
        stall_at_decode = 1'b1;
        bubble_at_exec  = 1'b1;
      end else if (branch_taken) begin
        bubble_at_decode = 1'b1;
        bubble_at_exec   = 1'b1;
        pc_sel           = 2'd1;
      end
      // Fetch starvation ORs onto the hazard/branch decisions.
      if (ic_miss || (state_q == IFILL) || (state_q == DRAIN)) begin
        stall_at_fetch   = 1'b1;
        bubble_at_decode = 1'b1;
      end
      // Holding and zeroing if_id are contradictory; the bubble wins.
      if (bubble_at_decode) stall_at_decode = 1'b0;
    end
  end

  // Memory port arbitration. DRAIN finishes a cancelled transfer so the
  // memory side never sees an abandoned request; its data is discarded.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dc_miss && !flush)                           state_d = DFILL;
        else if (ic_miss && !flush && !branch_taken)     state_d = IFILL;
      end
      IFILL: begin
        if (mem_ack)                                     state_d = IDLE;
        else if (flush || branch_taken)                  state_d = DRAIN;
      end
      DFILL: begin
        if (mem_ack)                                     state_d = IDLE;
        else if (flush)                                  state_d = DRAIN;
      end
      DRAIN: begin
        if (mem_ack)                                     state_d = IDLE;
      end
      default:                                           state_d = IDLE;
    endcase

    mem_req_d  = (state_d != IDLE);
    // DRAIN keeps the owner of the transfer it is completing.
    grant_dc_d = (state_d == DFILL) ||
                 ((state_d == DRAIN) && ((state_q == DFILL) ||
                                         ((state_q == DRAIN) && grant_dc_q)));

    if (exception_at_wb)  privilege_d = 1'b1;
    else if (iret_at_wb)  privilege_d = 1'b0;
    else                  privilege_d = privilege_q;

    if (stall_at_fetch && (stall_cycles_q != CNT_MAX))
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    else
      stall_cycles_d = stall_cycles_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      grant_dc_q     <= 1'b0;
      privilege_q    <= 1'b1;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      grant_dc_q     <= grant_dc_d;
      privilege_q    <= privilege_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_grant_dc = grant_dc_q;
  assign privilege    = privilege_q;
  assign stall_cycles = stall_cycles_q;

endmodule
